// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer: fetches from an external ROM, drives an ALU
// opcode, strobes register writes and resolves BNZ branches from the ALU flag.
module alu_sequencer #(
  parameter int PC_W = 10,
  parameter int IW   = 9
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [IW-1:0]   Instr,
  input  logic            AluBranch,
  output logic [PC_W-1:0] ProgCtr,
  output logic [3:0]      AluOp,
  output logic [2:0]      RdAddr,
  output logic            RegWrEn,
  output logic            Ack,
  output logic [15:0]     InstrCnt
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WB, S_DONE} state_t;

  localparam logic [3:0] OP_BNZ  = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_ir;
  logic            r_br;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_cnt;

  logic [3:0]      w_op;
  logic            w_halt;
  logic [PC_W-1:0] w_off;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_br;

  assign w_op     = r_ir[8:5];
  assign w_halt   = (w_op == OP_HALT);
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_pc_br  = r_pc + w_off;

  // Sign-extend (or truncate, for tiny PCs) the 5-bit branch offset to PC width.
  generate
    if (PC_W > 5) begin : g_off_ext
      assign w_off = {{(PC_W-5){r_ir[4]}}, r_ir[4:0]};
    end else if (PC_W == 5) begin : g_off_eq
      assign w_off = r_ir[4:0];
    end else begin : g_off_trunc
      assign w_off = r_ir[PC_W-1:0];
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_next = S_FETCH;
      S_FETCH: w_next = S_EXEC;
      S_EXEC:  w_next = w_halt ? S_DONE : S_WB;
      S_WB:    w_next = S_FETCH;
      S_DONE:  if (!Start) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    AluOp   = 4'd0;
    RegWrEn = 1'b0;
    Ack     = 1'b0;
    if ((r_state == S_EXEC || r_state == S_WB) && w_op <= OP_BNZ) begin
      AluOp = w_op;
    end
    if (r_state == S_WB && w_op < OP_BNZ) begin
      RegWrEn = 1'b1;
    end
    // Done is known as soon as HALT reaches EXEC.
    if (r_state == S_DONE || (r_state == S_EXEC && w_halt)) begin
      Ack = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ir  <= '0;
      r_br  <= 1'b0;
      r_pc  <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_pc  <= '0;
            r_cnt <= '0;
          end
        end
        S_FETCH: r_ir <= Instr;
        S_EXEC:  r_br <= AluBranch;
        S_WB: begin
          r_pc <= (w_op == OP_BNZ && r_br) ? w_pc_br : w_pc_inc;
          if (r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ProgCtr  = r_pc;
  assign RdAddr   = r_ir[4:2];
  assign InstrCnt = r_cnt;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scenario bench for alu_sequencer: a behavioural ROM feeds the DUT, expected
// register writes go through a scoreboard queue, cycle-exact checks elsewhere.
module tb_alu_sequencer;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  logic        Start;
  logic        AluBranch;
  logic [8:0]  Instr;
  logic [9:0]  ProgCtr;
  logic [3:0]  AluOp;
  logic [2:0]  RdAddr;
  logic        RegWrEn;
  logic        Ack;
  logic [15:0] InstrCnt;
  logic [8:0]  rom [0:1023];

  logic        Start4;
  logic [8:0]  Instr4;
  logic [3:0]  pc4;
  logic [3:0]  aluop4;
  logic [2:0]  rd4;
  logic        we4;
  logic        ack4;
  logic [15:0] cnt4;
  logic [8:0]  rom4 [0:15];

  always_comb Instr  = rom[ProgCtr];
  always_comb Instr4 = rom4[pc4];

  alu_sequencer u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instr(Instr), .AluBranch(AluBranch),
    .ProgCtr(ProgCtr), .AluOp(AluOp), .RdAddr(RdAddr), .RegWrEn(RegWrEn),
    .Ack(Ack), .InstrCnt(InstrCnt)
  );

  alu_sequencer #(.PC_W(4), .IW(9)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start4), .Instr(Instr4), .AluBranch(1'b0),
    .ProgCtr(pc4), .AluOp(aluop4), .RdAddr(rd4), .RegWrEn(we4),
    .Ack(ack4), .InstrCnt(cnt4)
  );

  typedef struct {
    int         cyc;
    logic [2:0] rd;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;

  localparam logic [8:0] HALT = 9'h1E0;

  function automatic logic [8:0] mk(input logic [3:0] op, input logic [2:0] rd);
    return {op, rd, 2'b00};
  endfunction

  function automatic logic [8:0] mkb(input logic [4:0] off);
    return {4'd9, off};
  endfunction

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
    cyc++;
  endtask

  task automatic clear_rom(input logic [8:0] w);
    for (int i = 0; i < 1024; i++) rom[i] = w;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Start = 1'b0;
    Start4 = 1'b0;
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    cyc = 0;
    step();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (ProgCtr !== 10'd0)  begin fails++; $display("FAIL reset_pc got=%0d exp=0", ProgCtr); end
    tests++; if (AluOp !== 4'd0)     begin fails++; $display("FAIL reset_aluop got=%0d exp=0", AluOp); end
    tests++; if (RegWrEn !== 1'b0)   begin fails++; $display("FAIL reset_we got=%b exp=0", RegWrEn); end
    tests++; if (Ack !== 1'b0)       begin fails++; $display("FAIL reset_ack got=%b exp=0", Ack); end
    tests++; if (InstrCnt !== 16'd0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", InstrCnt); end
    $display("[TB] reset: pc=%0d aluop=%0d we=%b ack=%b cnt=%0d", ProgCtr, AluOp, RegWrEn, Ack, InstrCnt);
  endtask

  task automatic test_program();
    wr_t       e;
    logic [3:0] exp_op;
    clear_rom(HALT);
    rom[0] = mk(4'd0, 3'd1);
    rom[1] = mk(4'd4, 3'd2);
    AluBranch = 1'b0;
    do_reset();
    exp_q.delete();
    exp_q.push_back('{cyc: 3, rd: 3'd1});
    exp_q.push_back('{cyc: 6, rd: 3'd2});
    start_pulse();
    for (int k = 0; k < 9; k++) begin
      if (RegWrEn === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL prog_unexpected_write cyc=%0d rd=%0d", cyc, RdAddr);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || RdAddr !== e.rd) begin
            fails++; $display("FAIL prog_write got cyc=%0d rd=%0d exp cyc=%0d rd=%0d", cyc, RdAddr, e.cyc, e.rd);
          end
        end
        $display("[TB] write cyc=%0d rd=%0d", cyc, RdAddr);
      end
      tests++;
      if (Ack !== 1'(cyc >= 8)) begin fails++; $display("FAIL prog_ack cyc=%0d got=%b exp=%b", cyc, Ack, cyc >= 8); end
      exp_op = (cyc == 5 || cyc == 6) ? 4'd4 : 4'd0;
      tests++;
      if (AluOp !== exp_op) begin fails++; $display("FAIL prog_aluop cyc=%0d got=%0d exp=%0d", cyc, AluOp, exp_op); end
      step();
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL prog_missing_writes left=%0d exp=0", exp_q.size()); end
    tests++; if (InstrCnt !== 16'd2) begin fails++; $display("FAIL prog_cnt got=%0d exp=2", InstrCnt); end
    tests++; if (Ack !== 1'b0) begin fails++; $display("FAIL prog_idle_ack got=%b exp=0", Ack); end
    $display("[TB] program: cnt=%0d pc=%0d", InstrCnt, ProgCtr);
  endtask

  task automatic run_bnz(input int addr, input logic [4:0] off, input logic br, input logic [9:0] exp_pc);
    int wb;
    clear_rom(mk(4'd10, 3'd0));
    rom[addr] = mkb(off);
    AluBranch = br;
    do_reset();
    start_pulse();
    wb = 3 * (addr + 1);
    while (cyc < wb) step();
    tests++; if (RegWrEn !== 1'b0) begin fails++; $display("FAIL bnz_we got=%b exp=0", RegWrEn); end
    tests++; if (AluOp !== 4'd9) begin fails++; $display("FAIL bnz_aluop got=%0d exp=9", AluOp); end
    step();
    tests++;
    if (ProgCtr !== exp_pc) begin
      fails++; $display("FAIL bnz_pc addr=%0d off=%0d br=%b got=%0d exp=%0d", addr, $signed(off), br, ProgCtr, exp_pc);
    end
    tests++;
    if (InstrCnt !== 16'(addr + 1)) begin fails++; $display("FAIL bnz_cnt got=%0d exp=%0d", InstrCnt, addr + 1); end
    $display("[TB] bnz addr=%0d off=%0d br=%b -> pc=%0d cnt=%0d", addr, $signed(off), br, ProgCtr, InstrCnt);
    AluBranch = 1'b0;
  endtask

  task automatic test_branch();
    run_bnz(5, 5'b11110, 1'b1, 10'd3);
    run_bnz(5, 5'b11110, 1'b0, 10'd6);
    run_bnz(5, 5'b00000, 1'b1, 10'd5);
    run_bnz(0, 5'b11111, 1'b1, 10'd1023);
  endtask

  task automatic test_reserved();
    clear_rom(HALT);
    rom[0] = mk(4'd12, 3'd7);
    do_reset();
    start_pulse();
    while (cyc < 3) step();
    tests++; if (RegWrEn !== 1'b0) begin fails++; $display("FAIL rsv_we got=%b exp=0", RegWrEn); end
    tests++; if (AluOp !== 4'd0)   begin fails++; $display("FAIL rsv_aluop got=%0d exp=0", AluOp); end
    step();
    tests++; if (ProgCtr !== 10'd1) begin fails++; $display("FAIL rsv_pc got=%0d exp=1", ProgCtr); end
    tests++; if (InstrCnt !== 16'd1) begin fails++; $display("FAIL rsv_cnt got=%0d exp=1", InstrCnt); end
    $display("[TB] reserved op12: pc=%0d cnt=%0d", ProgCtr, InstrCnt);
  endtask

  task automatic test_pc_wrap4();
    for (int i = 0; i < 16; i++) rom4[i] = mk(4'd0, 3'd3);
    do_reset();
    Start4 = 1'b1;
    cyc = 0;
    step();
    Start4 = 1'b0;
    while (cyc < 48) step();
    tests++; if (pc4 !== 4'd15) begin fails++; $display("FAIL wrap4_pre_pc got=%0d exp=15", pc4); end
    tests++; if (we4 !== 1'b1)  begin fails++; $display("FAIL wrap4_we got=%b exp=1", we4); end
    step();
    tests++; if (pc4 !== 4'd0)   begin fails++; $display("FAIL wrap4_pc got=%0d exp=0", pc4); end
    tests++; if (cnt4 !== 16'd16) begin fails++; $display("FAIL wrap4_cnt got=%0d exp=16", cnt4); end
    $display("[TB] pc_w4 wrap: pc=%0d cnt=%0d", pc4, cnt4);
  endtask

  task automatic test_reset_wb();
    clear_rom(HALT);
    rom[0] = mk(4'd0, 3'd5);
    do_reset();
    start_pulse();
    while (cyc < 3) step();
    tests++; if (RegWrEn !== 1'b1) begin fails++; $display("FAIL rstwb_pre_we got=%b exp=1", RegWrEn); end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    tests++; if (RegWrEn !== 1'b0)  begin fails++; $display("FAIL rstwb_we got=%b exp=0", RegWrEn); end
    tests++; if (ProgCtr !== 10'd0) begin fails++; $display("FAIL rstwb_pc got=%0d exp=0", ProgCtr); end
    tests++; if (Ack !== 1'b0)      begin fails++; $display("FAIL rstwb_ack got=%b exp=0", Ack); end
    tests++; if (InstrCnt !== 16'd0) begin fails++; $display("FAIL rstwb_cnt got=%0d exp=0", InstrCnt); end
    step();
    step();
    step();
    step();
    tests++; if (ProgCtr !== 10'd0) begin fails++; $display("FAIL rstwb_idle_pc got=%0d exp=0", ProgCtr); end
    $display("[TB] reset in WB: we=%b pc=%0d ack=%b", RegWrEn, ProgCtr, Ack);
  endtask

  task automatic test_back_to_back();
    clear_rom(HALT);
    rom[0] = mk(4'd0, 3'd1);
    do_reset();
    Start = 1'b1;
    cyc = 0;
    step();
    while (cyc <= 10) begin
      tests++;
      if (Ack !== 1'(cyc >= 5)) begin fails++; $display("FAIL held_ack cyc=%0d got=%b exp=%b", cyc, Ack, cyc >= 5); end
      step();
    end
    tests++; if (ProgCtr !== 10'd1)  begin fails++; $display("FAIL held_pc got=%0d exp=1", ProgCtr); end
    tests++; if (InstrCnt !== 16'd1) begin fails++; $display("FAIL held_cnt got=%0d exp=1", InstrCnt); end
    Start = 1'b0;
    step();
    tests++; if (Ack !== 1'b0) begin fails++; $display("FAIL drop_ack got=%b exp=0", Ack); end
    tests++; if (InstrCnt !== 16'd1) begin fails++; $display("FAIL idle_cnt got=%0d exp=1", InstrCnt); end
    Start = 1'b1;
    step();
    Start = 1'b0;
    tests++; if (InstrCnt !== 16'd0) begin fails++; $display("FAIL restart_cnt got=%0d exp=0", InstrCnt); end
    tests++; if (ProgCtr !== 10'd0)  begin fails++; $display("FAIL restart_pc got=%0d exp=0", ProgCtr); end
    $display("[TB] start held/drop/restart: ack=%b pc=%0d cnt=%0d", Ack, ProgCtr, InstrCnt);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Start4 = 1'b0;
    AluBranch = 1'b0;
    clear_rom(HALT);
    for (int i = 0; i < 16; i++) rom4[i] = HALT;
    test_reset();
    test_program();
    test_branch();
    test_reserved();
    test_pc_wrap4();
    test_reset_wb();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
